seq_detect_cfg: RTL and testbench
=================================

Name: seq_detect_cfg

Overview:
Configurable serial bit-sequence detector with Mealy output, the parametrised successor to the fixed-pattern mealyFSM. It shifts in one bit per valid cycle and flags completion of a runtime-programmed pattern of 1..PAT_W bits. It supports overlapping and non-overlapping match modes, input bubbles, and a saturating match counter. It sits between a serial bit source and a status/interrupt block.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter (>=2)
LEN_W, $clog2(PAT_W+1), derived width of cfg_len; not overridden

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
i_valid  input  1  i_d carries a sample this cycle
i_d  input  1  serial data bit
cfg_load  input  1  latch cfg_* and clear history (1-cycle pulse)
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  pattern length; 0 or >PAT_W is clamped to PAT_W
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after a match
cnt_clr  input  1  synchronous clear of match counter
o_d  output  1  Mealy match flag, combinational, same cycle as the final pattern bit
o_match_cnt  output  CNT_W  saturating count of matches
o_cnt_sat  output  1  high while o_match_cnt is all ones
o_armed  output  1  registered; high once configured (state HUNT)

Behaviour:
- Reset (async, reset_n=0): state UNCFG; history, fill, latched config, counter all 0; o_d=0, o_match_cnt=0, o_cnt_sat=0, o_armed=0.
- FSM has two states.
  - UNCFG: samples ignored, o_d=0. Moves to HUNT on cfg_load.
  - HUNT: detection active. cfg_load re-latches config and stays in HUNT.
- cfg_load: registers pattern, clamped len and overlap mode; clears history and fill to 0. If cfg_load and i_valid arrive together, the load wins: the sample is discarded and o_d=0. The new config applies from the next cycle.
- History update on an i_valid cycle in HUNT:
  - hist_nxt = {hist[PAT_W-2:0], i_d}.
  - fill_nxt = min(fill+1, PAT_W).
- Match condition (combinational): i_valid, state HUNT, no cfg_load, fill_nxt >= len, and hist_nxt[len-1:0] == pattern[len-1:0]. Bits above len are masked.
- o_d equals the match condition. It is never registered, so latency from the final bit to o_d is 0 cycles. o_d must not depend on i_d while i_valid=0.
- After a match:
  - cfg_overlap=1: hist/fill update normally.
  - cfg_overlap=0: hist and fill cleared to 0 at that clock edge, so the next match needs len fresh bits.
- i_valid=0 cycles are bubbles. hist/fill are held and partial matches survive any number of bubbles.
- Counter increments by 1 on each o_d=1 and saturates at 2^CNT_W-1 with no wrap. o_cnt_sat is registered and tracks the all-ones value.
- cnt_clr sets the counter to 0 next edge. If cnt_clr and o_d are high in the same cycle, clear wins and the result is 0. cnt_clr does not affect history.
- cfg_load does not clear the counter.
- Reset mid-pattern discards all history immediately; the block returns to UNCFG and requires a new cfg_load.

Test Plan:
1. PAT_W=8. Load pattern=8'b0000_1101, len=4, overlap=1. Stream 1,1,0,1,1,0,1 on consecutive valid cycles -> o_d=1 in the same cycle as bits 4 and 7. o_match_cnt=2.
2. Same as scenario 1 with overlap=0 -> o_d=1 only at bit 4. o_match_cnt=1. A further 1,1,0,1 -> o_d at the 4th bit.
3. Load len=3, pattern=101. Send 1, 0, then 3 cycles of i_valid=0 with i_d toggling, then 1 -> o_d=0 during the bubbles and o_d=1 on the final valid 1. cfg_load asserted together with a valid bit -> no o_d, fill=0.
4. Before any cfg_load, stream the pattern -> o_d stays 0 and o_armed=0. Assert reset_n=0 mid-pattern after arming, then release -> o_armed=0, counter 0, no match until reload.
5. CNT_W=3, len=1, pattern=1, overlap=1. Stream nine 1s -> o_match_cnt saturates at 7 from the 7th bit and o_cnt_sat=1. cnt_clr coincident with a match -> counter 0 next cycle.
6. cfg_len=0 and cfg_len=PAT_W+3 -> both behave as len=PAT_W. A full 8-bit pattern matches only after 8 valid bits.

Source files
------------

// File: rtl/seq_detect_cfg.sv
// rtl/seq_detect_cfg.sv - runtime-programmable serial bit-sequence detector with Mealy match flag
module seq_detect_cfg #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic             i_d,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             o_d,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_cnt_sat,
    output logic             o_armed
);

    typedef enum logic {
        UNCFG = 1'b0,
        HUNT  = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_nxt;
    logic [LEN_W-1:0]   fill_q, fill_nxt;
    logic [PAT_W-1:0]   pat_q;
    logic [LEN_W-1:0]   len_q, len_clamped;
    logic               ovl_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q;
    logic [PAT_W-1:0]   len_mask;
    logic               match;

    // State register: UNCFG until the first configuration load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any load arms the detector; nothing ever disarms it except reset
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = HUNT;
        end
    end

    // Outputs: match flag is Mealy and gated by i_valid so i_d is ignored in bubbles
    always_comb begin
        o_d     = 1'b0;
        o_armed = (state_q == HUNT);
        if (state_q == HUNT && i_valid && !cfg_load) begin
            o_d = match;
        end
    end

    // Candidate history/fill and pattern comparison masked to the programmed length
    always_comb begin
        hist_nxt    = {hist_q[PAT_W-2:0], i_d};
        fill_nxt    = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
        len_clamped = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        match = (fill_nxt >= len_q) && (((hist_nxt ^ pat_q) & len_mask) == '0);
    end

    // Configuration latch and shift history; non-overlap mode restarts after a match
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
        end else if (cfg_load) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= cfg_pattern;
            len_q  <= len_clamped;
            ovl_q  <= cfg_overlap;
        end else if (state_q == HUNT && i_valid) begin
            if (o_d && !ovl_q) begin
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= hist_nxt;
                fill_q <= fill_nxt;
            end
        end
    end

    // Saturating match counter; clear has priority over a coincident match
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (o_d && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and saturation flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= (cnt_d == CNT_MAX);
        end
    end

    assign o_match_cnt = cnt_q;
    assign o_cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_cfg.sv
// tb/tb_seq_detect_cfg.sv - scoreboard bench for seq_detect_cfg
module tb_seq_detect_cfg;

    localparam int PAT_W = 8;
    localparam int CNT_W = 3;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_d = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             o_d;
    logic [CNT_W-1:0] o_match_cnt;
    logic             o_cnt_sat;
    logic             o_armed;

    seq_detect_cfg #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_valid     (i_valid),
        .i_d         (i_d),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .o_d         (o_d),
        .o_match_cnt (o_match_cnt),
        .o_cnt_sat   (o_cnt_sat),
        .o_armed     (o_armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        kind;
        int        val;
        string     name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic expect_out(input int kind, input int val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit v, input bit d, input bit ld, input bit clr,
                       input bit exp_od, input string name);
        i_valid  = v;
        i_d      = d;
        cfg_load = ld;
        cnt_clr  = clr;
        expect_out(0, int'(exp_od), name);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, name);
    endtask

    task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                        input bit ovl, input string name);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, name);
    endtask

    // Monitor: compares every queued expectation against the outputs at the falling edge
    always @(negedge clk) begin
        int act;
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                0:       act = int'(o_d);
                1:       act = int'(o_match_cnt);
                2:       act = int'(o_cnt_sat);
                default: act = int'(o_armed);
            endcase
            n_checks++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit b;
        logic [7:0] seq;

        // Reset state
        @(posedge clk); #1;
        expect_out(1, 0, "rst_cnt");
        expect_out(2, 0, "rst_sat");
        expect_out(3, 0, "rst_armed");
        idle("rst_od");
        reset_n = 1'b1;
        idle("post_rst");

        // Unconfigured: pattern stream ignored
        cfg_pattern = 8'b0000_1101;
        cfg_len = 4'd4;
        cfg_overlap = 1'b1;
        seq = 8'b1101;
        for (int i = 3; i >= 0; i--) begin
            b = seq[i];
            cyc(1'b1, b, 1'b0, 1'b0, 1'b0, "uncfg_od");
        end
        expect_out(3, 0, "uncfg_armed");
        idle("uncfg_idle");

        // Overlapping: 1101101 matches at bits 4 and 7
        load(8'b0000_1101, 4'd4, 1'b1, "s1_load");
        expect_out(3, 1, "s1_armed");
        cyc(1, 1, 0, 0, 0, "s1_b1");
        cyc(1, 1, 0, 0, 0, "s1_b2");
        cyc(1, 0, 0, 0, 0, "s1_b3");
        cyc(1, 1, 0, 0, 1, "s1_b4");
        cyc(1, 1, 0, 0, 0, "s1_b5");
        cyc(1, 0, 0, 0, 0, "s1_b6");
        cyc(1, 1, 0, 0, 1, "s1_b7");
        expect_out(1, 2, "s1_cnt");
        idle("s1_idle");

        // Non-overlapping: only bit 4 matches, then fresh 1101 needed
        cyc(0, 0, 0, 1, 0, "s2_clr");
        expect_out(1, 0, "s2_cnt_clr");
        load(8'b0000_1101, 4'd4, 1'b0, "s2_load");
        cyc(1, 1, 0, 0, 0, "s2_b1");
        cyc(1, 1, 0, 0, 0, "s2_b2");
        cyc(1, 0, 0, 0, 0, "s2_b3");
        cyc(1, 1, 0, 0, 1, "s2_b4");
        cyc(1, 1, 0, 0, 0, "s2_b5");
        cyc(1, 0, 0, 0, 0, "s2_b6");
        cyc(1, 1, 0, 0, 0, "s2_b7");
        cyc(1, 1, 0, 0, 0, "s2_c1");
        cyc(1, 1, 0, 0, 0, "s2_c2");
        cyc(1, 0, 0, 0, 0, "s2_c3");
        cyc(1, 1, 0, 0, 1, "s2_c4");
        expect_out(1, 2, "s2_cnt");
        idle("s2_idle");

        // Bubbles preserve partial match; upper pattern bits masked
        load(8'b1111_0101, 4'd3, 1'b1, "s3_load");
        cyc(1, 1, 0, 0, 0, "s3_b1");
        cyc(1, 0, 0, 0, 0, "s3_b2");
        cyc(0, 1, 0, 0, 0, "s3_bub1");
        cyc(0, 0, 0, 0, 0, "s3_bub2");
        cyc(0, 1, 0, 0, 0, "s3_bub3");
        cyc(1, 1, 0, 0, 1, "s3_b3");
        cyc(1, 0, 0, 0, 0, "s3_b4");
        // Load with a completing bit: load wins, sample discarded, history cleared
        cyc(1, 1, 1, 0, 0, "s3_load_valid");
        cyc(1, 1, 0, 0, 0, "s3_fresh1");
        cyc(1, 0, 0, 0, 0, "s3_fresh2");
        cyc(1, 1, 0, 0, 1, "s3_fresh3");
        expect_out(1, 4, "s3_cnt_kept");
        idle("s3_idle");

        // len=0 clamps to full width, non-overlap
        seq = 8'b1011_0010;
        load(seq, 4'd0, 1'b0, "s6_load0");
        for (int i = 7; i >= 0; i--) begin
            b = seq[i];
            cyc(1'b1, b, 1'b0, 1'b0, (i == 0), "s6_len0");
        end
        // len beyond PAT_W clamps to full width
        load(seq, 4'(PAT_W + 3), 1'b1, "s6_load11");
        for (int i = 7; i >= 0; i--) begin
            b = seq[i];
            cyc(1'b1, b, 1'b0, 1'b0, (i == 0), "s6_len11");
        end

        // Saturation with len=1
        cyc(0, 0, 0, 1, 0, "s5_clr");
        load(8'b0000_0001, 4'd1, 1'b1, "s5_load");
        for (int i = 1; i <= 9; i++) begin
            if (i == 7) begin
                expect_out(1, 6, "s5_cnt6");
                expect_out(2, 0, "s5_sat0");
            end
            cyc(1, 1, 0, 0, 1, "s5_bit");
        end
        expect_out(1, 7, "s5_cnt_sat");
        expect_out(2, 1, "s5_sat1");
        cyc(1, 1, 0, 1, 1, "s5_clr_match");
        expect_out(1, 0, "s5_cnt_after_clr");
        expect_out(2, 0, "s5_sat_after_clr");
        idle("s5_idle");

        // Reset mid-pattern after arming
        load(8'b0000_1101, 4'd4, 1'b1, "s4_load");
        cyc(1, 1, 0, 0, 0, "s4_b1");
        cyc(1, 1, 0, 0, 0, "s4_b2");
        cyc(1, 0, 0, 0, 0, "s4_b3");
        reset_n = 1'b0;
        expect_out(3, 0, "s4_rst_armed");
        expect_out(1, 0, "s4_rst_cnt");
        idle("s4_rst");
        reset_n = 1'b1;
        cyc(1, 1, 0, 0, 0, "s4_b4");
        seq = 8'b1101;
        for (int i = 3; i >= 0; i--) begin
            b = seq[i];
            cyc(1'b1, b, 1'b0, 1'b0, 1'b0, "s4_noreload");
        end
        expect_out(3, 0, "s4_armed");
        expect_out(1, 0, "s4_cnt");
        idle("s4_idle");

        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
